// File: rtl/alu_io_pkg.sv
`default_nettype none
// ============================================================================
// alu_io_pkg : shared word layout and serializer states for ALU result output
// Rev 1.0
// ============================================================================
package alu_io_pkg;

    localparam int RES_W    = 27;

    localparam int OUT1_LSB = 0;
    localparam int OUT2_LSB = 8;
    localparam int C1_BIT   = 16;
    localparam int C2_BIT   = 17;
    localparam int X_LSB    = 18;
    localparam int Y_BIT    = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_res_fifo.sv
`default_nettype none
// ============================================================================
// alu_res_fifo : synchronous FIFO holding packed ALU result words
// Rev 1.0
// ============================================================================
module alu_res_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/alu_result_serializer.sv
`default_nettype none
// ============================================================================
// alu_result_serializer : queues ALU result sets and shifts them out MSB-first
// Rev 1.0
// ============================================================================
module alu_result_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             ALU_Out1,
    input  logic [7:0]             ALU_Out2,
    input  logic                   CarryOut1,
    input  logic                   CarryOut2,
    input  logic [7:0]             x,
    input  logic                   y,
    output logic                   in_ready,
    input  logic                   ser_en,
    output logic                   ser_dat,
    output logic                   ser_frame,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    import alu_io_pkg::*;

    localparam int                 c_cnt_w    = $clog2(RES_W);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(RES_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [RES_W-1:0]   w_word;
    logic [RES_W-1:0]   w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    ser_state_t         r_state;
    logic [RES_W-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic               r_ser_dat;
    logic               r_ser_frame;
    logic               r_overflow;

    always_comb begin
        w_word                   = '0;
        w_word[OUT1_LSB +: 8]    = ALU_Out1;
        w_word[OUT2_LSB +: 8]    = ALU_Out2;
        w_word[C1_BIT]           = CarryOut1;
        w_word[C2_BIT]           = CarryOut2;
        w_word[X_LSB +: 8]       = x;
        w_word[Y_BIT]            = y;
    end

    // Fullness is judged on the start-of-cycle count; a same-cycle pop never makes room.
    assign w_push = in_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty;

    alu_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n),
        .push    (w_push),
        .wr_data (w_word),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_ser_dat   <= 1'b0;
            r_ser_frame <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shreg     <= w_head;
                        r_bit_cnt   <= '0;
                        r_ser_dat   <= w_head[RES_W-1];
                        r_ser_frame <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        if (r_bit_cnt == c_last_bit) begin
                            r_ser_dat   <= 1'b0;
                            r_ser_frame <= 1'b0;
                            r_state     <= GAP;
                        end else begin
                            r_shreg   <= r_shreg << 1;
                            r_bit_cnt <= r_bit_cnt + c_cnt_one;
                            r_ser_dat <= r_shreg[RES_W-2];
                        end
                    end
                end
                // One idle-frame bit period lets the sink resynchronize between words.
                GAP: begin
                    if (ser_en) r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_ser_dat   <= 1'b0;
                    r_ser_frame <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign ser_dat   = r_ser_dat;
    assign ser_frame = r_ser_frame;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
